sa_tile_ctrl: RTL and testbench

Parametrised sequencing controller for the systolic array datapath. It fills the operand buffer from an AXIS slave stream, feeds the buffered beats into the array, and waits for the array's result-valid. It can accumulate several tiles without clearing the array, then drains a configurable number of result rows to an AXIS master with TLAST. It sits between the AXIS input/output wrappers, the operand buffer and the array, and replaces the fixed single-tile controller.

---
 rtl/sa_ctrl_pkg.sv | 7 +
 rtl/sa_beat_counter.sv | 21 ++
 rtl/sa_tile_ctrl.sv | 142 ++++++++++++++
 tb/tb_sa_tile_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sa_ctrl_pkg.sv
// sa_ctrl_pkg: shared state encoding and default geometry for the systolic tile controller
package sa_ctrl_pkg;
    typedef enum logic [2:0] {CLEAR, FILL, FEED, WAIT_C, DRAIN} state_t;
    localparam int DEF_IN_BEATS  = 8;
    localparam int DEF_OUT_BEATS = 4;
    localparam int DEF_TILE_W    = 8;
endpackage

// File: rtl/sa_beat_counter.sv
// sa_beat_counter: up-counter with clear priority over enable and terminal-count flag
module sa_beat_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
    assign tc  = cnt_q == last;
endmodule

// File: rtl/sa_tile_ctrl.sv
// sa_tile_ctrl: fill/feed/wait/drain sequencer for the systolic array; SA_WATCHDOG_EN adds a WAIT_C timeout with sticky o_err
module sa_tile_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int IN_BEATS    = DEF_IN_BEATS,
    parameter int OUT_BEATS   = DEF_OUT_BEATS,
    parameter int TILE_W      = DEF_TILE_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         s_axis_valid,
    input  logic                         s_axis_last,
    output logic                         s_axis_ready,
    input  logic                         m_axis_ready,
    output logic                         m_axis_valid,
    output logic                         m_axis_last,
    input  logic                         buff_is_empty,
    input  logic                         buff_is_full,
    output logic                         buff_clr,
    output logic                         buff_wr,
    output logic                         buff_rd,
    output logic                         arr_clr,
    output logic                         arr_en,
    input  logic                         arr_C_valid,
    output logic [$clog2(OUT_BEATS)-1:0] out_sel,
    input  logic [TILE_W-1:0]            cfg_accum_tiles,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err
);
    localparam int BW = $clog2(IN_BEATS + 1);
    localparam int OW = $clog2(OUT_BEATS);
    state_t state_q, state_d;
    logic [BW-1:0] feed_lim_q, feed_lim_d, bcnt, blast;
    logic [TILE_W-1:0] acc_lim_q, acc_lim_d, tcnt;
    logic [OW-1:0] ocnt;
    logic o_done_q, o_done_d, btc, otc, ttc, wd_trip;
    // one counter serves both FILL and FEED; it restarts on every state change
    assign blast = state_q == FEED ? feed_lim_q - 1'b1 : BW'(IN_BEATS - 1);
    sa_beat_counter #(.W(BW)) u_beat (
        .i_clk(i_clk), .i_rst(i_rst), .clr(state_d != state_q), .en(buff_wr | buff_rd),
        .last(blast), .cnt(bcnt), .tc(btc)
    );
    sa_beat_counter #(.W(OW)) u_out (
        .i_clk(i_clk), .i_rst(i_rst), .clr(state_q == CLEAR), .en(m_axis_valid & m_axis_ready),
        .last(OW'(OUT_BEATS - 1)), .cnt(ocnt), .tc(otc)
    );
    sa_beat_counter #(.W(TILE_W)) u_tile (
        .i_clk(i_clk), .i_rst(i_rst), .clr(state_q == CLEAR), .en(state_q == WAIT_C & arr_C_valid),
        .last(acc_lim_q - 1'b1), .cnt(tcnt), .tc(ttc)
    );
    always_comb begin
        state_d      = state_q;
        feed_lim_d   = feed_lim_q;
        acc_lim_d    = acc_lim_q;
        o_done_d     = 1'b0;
        s_axis_ready = 1'b0;
        buff_wr      = 1'b0;
        buff_rd      = 1'b0;
        arr_en       = 1'b0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        out_sel      = '0;
        buff_clr     = i_rst || state_q == CLEAR;
        arr_clr      = buff_clr;
        o_busy       = !i_rst && !(state_q == FILL && bcnt == '0 && tcnt == '0);
        if (!i_rst) begin
            case (state_q)
                CLEAR: begin
                    acc_lim_d = cfg_accum_tiles == '0 ? TILE_W'(1) : cfg_accum_tiles;
                    state_d   = FILL;
                end
                FILL: begin
                    s_axis_ready = !buff_is_full;
                    buff_wr      = s_axis_valid && !buff_is_full;
                    if (buff_wr && (btc || s_axis_last)) begin
                        feed_lim_d = bcnt + 1'b1;
                        state_d    = FEED;
                    end
                end
                FEED: begin
                    buff_rd = !buff_is_empty;
                    arr_en  = 1'b1;
                    if (buff_rd && btc) state_d = WAIT_C;
                end
                WAIT_C: begin
                    arr_en = 1'b1;
                    if (arr_C_valid) state_d = ttc ? DRAIN : FILL;
                    else if (wd_trip) state_d = CLEAR;
                end
                DRAIN: begin
                    m_axis_valid = 1'b1;
                    m_axis_last  = otc;
                    out_sel      = ocnt;
                    if (m_axis_ready && otc) begin
                        o_done_d = 1'b1;
                        state_d  = CLEAR;
                    end
                end
                default: state_d = CLEAR;
            endcase
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= CLEAR;
            feed_lim_q <= '0;
            acc_lim_q  <= '0;
            o_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            feed_lim_q <= feed_lim_d;
            acc_lim_q  <= acc_lim_d;
            o_done_q   <= o_done_d;
        end
    end
    assign o_done = o_done_q;
`ifdef SA_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYC);
    logic [WDW-1:0] wd_q, wd_d;
    logic o_err_q, o_err_d;
    always_comb begin
        wd_trip = state_q == WAIT_C && !arr_C_valid && wd_q == WDW'(TIMEOUT_CYC - 1);
        wd_d    = state_q == WAIT_C && !arr_C_valid && !wd_trip ? wd_q + 1'b1 : '0;
        o_err_d = o_err_q | wd_trip;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_q    <= '0;
            o_err_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            o_err_q <= o_err_d;
        end
    end
    assign o_err = o_err_q;
`else
    assign wd_trip = 1'b0;
    assign o_err   = 1'b0;
`endif
endmodule

// File: tb/tb_sa_tile_ctrl.sv
// tb_sa_tile_ctrl: scoreboard bench for sa_tile_ctrl with a simple occupancy model of the operand buffer
module tb_sa_tile_ctrl;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic s_axis_valid = 1'b0, s_axis_last = 1'b0, s_axis_ready;
    logic m_axis_ready = 1'b0, m_axis_valid, m_axis_last;
    logic buff_is_empty, buff_is_full, buff_clr, buff_wr, buff_rd;
    logic arr_clr, arr_en, arr_C_valid = 1'b0;
    logic [1:0] out_sel;
    logic [7:0] cfg_accum_tiles = 8'd1;
    logic o_busy, o_done, o_err;
    int checks = 0, errors = 0;
    int wr_cnt = 0, rd_cnt = 0, hs_cnt = 0, arr_cnt = 0, done_cnt = 0, wait_cyc = 0, occ = 0;
    bit force_full = 1'b0;
    int exp_q[$];
    bit stall_prev = 1'b0, last_hs_prev = 1'b0;
    logic [1:0] sel_prev;
    logic last_prev;
    sa_tile_ctrl #(.IN_BEATS(8), .OUT_BEATS(4), .TILE_W(8), .TIMEOUT_CYC(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .s_axis_valid(s_axis_valid), .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
        .m_axis_ready(m_axis_ready), .m_axis_valid(m_axis_valid), .m_axis_last(m_axis_last),
        .buff_is_empty(buff_is_empty), .buff_is_full(buff_is_full), .buff_clr(buff_clr),
        .buff_wr(buff_wr), .buff_rd(buff_rd), .arr_clr(arr_clr), .arr_en(arr_en),
        .arr_C_valid(arr_C_valid), .out_sel(out_sel), .cfg_accum_tiles(cfg_accum_tiles),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );
    always #5 i_clk = ~i_clk;
    assign buff_is_empty = occ == 0;
    assign buff_is_full  = occ >= 8 || force_full;
    always @(posedge i_clk) occ <= buff_clr ? 0 : occ + int'(buff_wr) - int'(buff_rd);
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (buff_wr) wr_cnt++;
            if (buff_rd) rd_cnt++;
            if (arr_clr) arr_cnt++;
            if (arr_en && !buff_rd) wait_cyc++;
            if (stall_prev) begin
                chk("hold_valid", m_axis_valid, 1);
                chk("hold_sel", out_sel, sel_prev);
                chk("hold_last", m_axis_last, last_prev);
            end
            if (o_done || last_hs_prev) chk("done_pulse", o_done, last_hs_prev);
            if (o_done) done_cnt++;
            if (m_axis_valid && m_axis_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) chk("rows_pending", exp_q.size(), 1);
                else chk("row", {29'b0, out_sel, m_axis_last}, exp_q.pop_front());
            end
            stall_prev   = m_axis_valid && !m_axis_ready;
            sel_prev     = out_sel;
            last_prev    = m_axis_last;
            last_hs_prev = m_axis_valid && m_axis_ready && m_axis_last;
        end else begin
            stall_prev   = 1'b0;
            last_hs_prev = 1'b0;
        end
    end
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask
    task automatic do_reset(input int acc);
        cfg_accum_tiles = 8'(acc);
        i_rst = 1'b1;
        s_axis_valid = 1'b0;
        s_axis_last = 1'b0;
        m_axis_ready = 1'b0;
        arr_C_valid = 1'b0;
        @(negedge i_clk);
        chk("rst_outs", {buff_clr, arr_clr, s_axis_ready, buff_wr, buff_rd, arr_en,
                         m_axis_valid, m_axis_last, o_busy, o_done, out_sel}, 12'b1100_0000_0000);
        tick();
        i_rst = 1'b0;
        {wr_cnt, rd_cnt, hs_cnt, arr_cnt, done_cnt, wait_cyc} = '0;
        exp_q.delete();
        @(negedge i_clk);
        chk("clear_outs", {buff_clr, arr_clr, o_busy, s_axis_ready}, 4'b1110);
        tick();
        chk("idle_busy", o_busy, 0);
    endtask
    task automatic fill(input int n, input bit short_tile);
        int i = 0;
        int g = 0;
        bit acc;
        while (i < n && g < 100) begin
            s_axis_valid = 1'b1;
            s_axis_last = short_tile && i == n - 1;
            @(negedge i_clk);
            acc = s_axis_ready;
            tick();
            if (acc) i++;
            g++;
        end
        s_axis_valid = 1'b0;
        s_axis_last = 1'b0;
        chk("fill_beats", i, n);
    endtask
    task automatic feed_wait(input int target);
        int g = 0;
        while (rd_cnt < target && g < 100) begin
            tick();
            g++;
        end
        chk("feed_reads", rd_cnt, target);
    endtask
    task automatic pulse_c();
        arr_C_valid = 1'b1;
        tick();
        arr_C_valid = 1'b0;
    endtask
    task automatic drain(input bit stall);
        bit [5:0] pat = 6'b111001;
        int k = 0;
        int d0 = done_cnt;
        for (int r = 0; r < 4; r++) exp_q.push_back(r * 2 + int'(r == 3));
        while (!m_axis_valid && k < 50) begin
            tick();
            k++;
        end
        k = 0;
        while (done_cnt == d0 && k < 50) begin
            m_axis_ready = stall && k < 6 ? pat[k] : 1'b1;
            tick();
            k++;
        end
        m_axis_ready = 1'b0;
        chk("drain_done", done_cnt, d0 + 1);
        chk("rows_left", exp_q.size(), 0);
    endtask
    initial begin
        do_reset(1);
        force_full = 1'b1;
        s_axis_valid = 1'b1;
        repeat (3) tick();
        chk("full_stall_wr", wr_cnt, 0);
        chk("full_stall_rdy", s_axis_ready, 0);
        force_full = 1'b0;
        s_axis_valid = 1'b0;
        fill(8, 1'b0);
        feed_wait(8);
        chk("t1_wr", wr_cnt, 8);
        pulse_c();
        drain(1'b0);
        chk("t1_rd", rd_cnt, 8);
        chk("t1_hs", hs_cnt, 4);
        do_reset(1);
        fill(5, 1'b1);
        feed_wait(5);
        pulse_c();
        drain(1'b0);
        chk("t2_wr", wr_cnt, 5);
        chk("t2_rd", rd_cnt, 5);
        do_reset(3);
        for (int t = 0; t < 3; t++) begin
            fill(8, 1'b0);
            feed_wait(8 * (t + 1));
            pulse_c();
            if (t < 2) chk("accum_busy", o_busy, 1);
        end
        drain(1'b0);
        chk("t3_arr_clr", arr_cnt, 2);
        chk("t3_hs", hs_cnt, 4);
        chk("t3_rd", rd_cnt, 24);
        do_reset(1);
        fill(8, 1'b0);
        feed_wait(8);
        pulse_c();
        drain(1'b1);
        chk("t4_hs", hs_cnt, 4);
        do_reset(1);
        fill(8, 1'b0);
        for (int g = 0; g < 50 && rd_cnt < 3; g++) tick();
        chk("t5_mid_feed", rd_cnt, 3);
        do_reset(1);
        fill(8, 1'b0);
        feed_wait(8);
        pulse_c();
        drain(1'b0);
        chk("t5_wr", wr_cnt, 8);
        chk("t5_rd", rd_cnt, 8);
`ifdef SA_WATCHDOG_EN
        do_reset(1);
        fill(8, 1'b0);
        feed_wait(8);
        wait_cyc = 0;
        for (int g = 0; g < 40 && !o_err; g++) tick();
        chk("wd_err", o_err, 1);
        chk("wd_cycles", wait_cyc, 16);
        chk("wd_clear", buff_clr, 1);
        repeat (5) tick();
        chk("wd_sticky", o_err, 1);
        do_reset(1);
        chk("wd_cleared", o_err, 0);
`else
        chk("err_tied", o_err, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
